// File: rtl/button_reader.sv
// button_reader: synchronizes and debounces raw push-buttons and turns them
// into clean levels, press/release/long-press strobes and a press counter.
module button_reader #(
  parameter int unsigned NUM_BTN           = 3,
  parameter int unsigned DEBOUNCE_CYCLES   = 270000,
  parameter int unsigned LONG_PRESS_CYCLES = 13500000,
  parameter bit          ACTIVE_LOW        = 1'b1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_BTN-1:0] btn_in,
  output logic [NUM_BTN-1:0] btn_state,
  output logic [NUM_BTN-1:0] press_pulse,
  output logic [NUM_BTN-1:0] release_pulse,
  output logic [NUM_BTN-1:0] long_pulse,
  output logic [7:0]         press_count
);

  localparam int unsigned DW = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned HW = (LONG_PRESS_CYCLES < 2) ? 1 : $clog2(LONG_PRESS_CYCLES + 1);

  localparam logic [DW-1:0]      DEB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0]      HOLD_MAX  = HW'(LONG_PRESS_CYCLES);
  localparam logic [HW-1:0]      HOLD_LAST = HW'(LONG_PRESS_CYCLES - 1);
  localparam logic [NUM_BTN-1:0] RELEASED  = {NUM_BTN{ACTIVE_LOW}};

  logic [NUM_BTN-1:0] sync1_q, sync2_q;
  logic [NUM_BTN-1:0] pressed_s;

  logic [DW-1:0]      deb_cnt_q  [NUM_BTN];
  logic [DW-1:0]      deb_cnt_d  [NUM_BTN];
  logic [HW-1:0]      hold_cnt_q [NUM_BTN];
  logic [HW-1:0]      hold_cnt_d [NUM_BTN];

  logic [NUM_BTN-1:0] state_q, state_d;
  logic [NUM_BTN-1:0] press_q, press_d;
  logic [NUM_BTN-1:0] rel_q, rel_d;
  logic [NUM_BTN-1:0] long_q, long_d;
  logic [7:0]         count_q, count_d;
  logic [7:0]         press_inc;

  // Second synchronizer stage normalized so 1 always means pressed.
  assign pressed_s = sync2_q ^ RELEASED;

  // Two-flop synchronizer; reset loads the released level to avoid a false press.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q <= RELEASED;
      sync2_q <= RELEASED;
    end else begin
      sync1_q <= btn_in;
      sync2_q <= sync1_q;
    end
  end

  // Debounce, pulse, long-press and press-count next-state logic.
  always_comb begin
    state_d   = state_q;
    press_d   = '0;
    rel_d     = '0;
    long_d    = '0;
    press_inc = '0;
    for (int unsigned i = 0; i < NUM_BTN; i++) begin
      deb_cnt_d[i]  = deb_cnt_q[i];
      hold_cnt_d[i] = hold_cnt_q[i];

      if (pressed_s[i] == state_q[i]) begin
        deb_cnt_d[i] = '0;
      end else if (deb_cnt_q[i] == DEB_LAST) begin
        state_d[i]   = ~state_q[i];
        deb_cnt_d[i] = '0;
      end else begin
        deb_cnt_d[i] = deb_cnt_q[i] + DW'(1);
      end

      // Pulses are computed from the edge-to-edge level change so they land
      // in the first cycle of the new debounced level.
      press_d[i] = state_d[i] & ~state_q[i];
      rel_d[i]   = ~state_d[i] & state_q[i];

      // hold_cnt holds the 1-based index of the current pressed cycle and
      // saturates at the threshold, so the strobe fires once per press.
      if (!state_d[i]) begin
        hold_cnt_d[i] = '0;
      end else if (hold_cnt_q[i] != HOLD_MAX) begin
        hold_cnt_d[i] = hold_cnt_q[i] + HW'(1);
      end
      long_d[i] = state_d[i] && (hold_cnt_q[i] == HOLD_LAST);

      press_inc = press_inc + 8'(press_q[i]);
    end
    count_d = count_q + press_inc;
  end

  // State registers for all per-button and shared outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= '0;
      press_q <= '0;
      rel_q   <= '0;
      long_q  <= '0;
      count_q <= '0;
      for (int unsigned i = 0; i < NUM_BTN; i++) begin
        deb_cnt_q[i]  <= '0;
        hold_cnt_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      press_q <= press_d;
      rel_q   <= rel_d;
      long_q  <= long_d;
      count_q <= count_d;
      for (int unsigned i = 0; i < NUM_BTN; i++) begin
        deb_cnt_q[i]  <= deb_cnt_d[i];
        hold_cnt_q[i] <= hold_cnt_d[i];
      end
    end
  end

  assign btn_state     = state_q;
  assign press_pulse   = press_q;
  assign release_pulse = rel_q;
  assign long_pulse    = long_q;
  assign press_count   = count_q;

endmodule

// File: tb/tb_button_reader.sv
// Testbench for button_reader: directed scenarios plus randomized pin
// activity, all checked cycle by cycle against a behavioural model.
module tb_button_reader;

  localparam int unsigned NB   = 3;
  localparam int          DEB  = 4;
  localparam int          LONG = 10;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [NB-1:0] btn_in = '1;
  logic [NB-1:0] btn_state, press_pulse, release_pulse, long_pulse;
  logic [7:0]    press_count;

  int n_checks = 0;
  int n_errors = 0;

  button_reader #(
    .NUM_BTN(NB),
    .DEBOUNCE_CYCLES(DEB),
    .LONG_PRESS_CYCLES(LONG),
    .ACTIVE_LOW(1'b1)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .btn_in(btn_in),
    .btn_state(btn_state),
    .press_pulse(press_pulse),
    .release_pulse(release_pulse),
    .long_pulse(long_pulse),
    .press_count(press_count)
  );

  always #5 clk = ~clk;

  // Reference model: pressed levels seen by the logic lag the pins by two
  // edges; a level is accepted after DEB consecutive disagreeing samples.
  logic [NB-1:0] dq[$];
  logic [NB-1:0] m_state, m_press, m_rel, m_long;
  logic [7:0]    m_count;
  int            m_run  [NB];
  int            m_hold [NB];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_edge(input logic rst, input logic [NB-1:0] pins);
    logic [NB-1:0] s;
    logic [NB-1:0] nstate;
    if (!rst) begin
      dq = {};
      dq.push_back('0);
      dq.push_back('0);
      m_state = '0; m_press = '0; m_rel = '0; m_long = '0; m_count = '0;
      for (int i = 0; i < NB; i++) begin
        m_run[i] = 0;
        m_hold[i] = 0;
      end
    end else begin
      m_count = m_count + 8'($countones(m_press));
      s = dq.pop_front();
      dq.push_back(~pins);
      nstate = m_state;
      for (int i = 0; i < NB; i++) begin
        if (s[i] != m_state[i]) m_run[i]++;
        else m_run[i] = 0;
        if (m_run[i] == DEB) begin
          nstate[i] = s[i];
          m_run[i] = 0;
        end
        if (nstate[i]) m_hold[i]++;
        else m_hold[i] = 0;
        m_long[i] = nstate[i] && (m_hold[i] == LONG);
      end
      m_press = nstate & ~m_state;
      m_rel   = ~nstate & m_state;
      m_state = nstate;
    end
  endtask

  // One clock: drive, let the edge happen, update model, compare mid-cycle.
  task automatic step(input logic [NB-1:0] pins, input logic rst);
    btn_in = pins;
    rst_n  = rst;
    @(posedge clk);
    model_edge(rst, pins);
    @(negedge clk);
    check_eq("btn_state", 32'(btn_state), 32'(m_state));
    check_eq("press_pulse", 32'(press_pulse), 32'(m_press));
    check_eq("release_pulse", 32'(release_pulse), 32'(m_rel));
    check_eq("long_pulse", 32'(long_pulse), 32'(m_long));
    check_eq("press_count", 32'(press_count), 32'(m_count));
  endtask

  task automatic press_and_release(input logic [NB-1:0] low_pins);
    for (int k = 0; k < 8; k++) step(low_pins, 1'b1);
    for (int k = 0; k < 8; k++) step('1, 1'b1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lat, p, r, lstep, nlong, rise;
    logic [7:0] base;
    logic triple_seen;
    int rem [NB];
    logic [NB-1:0] lvl;

    // 1: reset then idle
    for (int k = 0; k < 3; k++) step('1, 1'b0);
    for (int k = 0; k < 20; k++) step('1, 1'b1);
    check_eq("t1_idle_count", 32'(press_count), 32'd0);

    // 2: clean press on button 0
    lat = -1;
    for (int k = 1; k <= 20; k++) begin
      step(3'b110, 1'b1);
      if (lat < 0 && btn_state[0]) begin
        lat = k;
        check_eq("t2_pulse_at_rise", 32'(press_pulse[0]), 32'd1);
      end
    end
    check_eq("t2_latency", 32'(lat), 32'd6);
    check_eq("t2_count", 32'(press_count), 32'd1);
    for (int k = 0; k < 10; k++) step('1, 1'b1);

    // 3: glitches on button 1
    base = m_count;
    rise = 0;
    for (int w = 1; w <= 3; w++) begin
      for (int k = 0; k < w; k++) begin step(3'b101, 1'b1); if (btn_state[1]) rise = 1; end
      for (int k = 0; k < 3; k++) begin step('1, 1'b1); if (btn_state[1]) rise = 1; end
    end
    for (int k = 0; k < 10; k++) begin step('1, 1'b1); if (btn_state[1]) rise = 1; end
    check_eq("t3_no_rise", 32'(rise), 32'd0);
    check_eq("t3_count", 32'(press_count), 32'(base));

    // 4: long hold on button 2, then short hold
    p = -1; lstep = -1; nlong = 0; r = -1;
    for (int k = 1; k <= 30; k++) begin
      step(3'b011, 1'b1);
      if (press_pulse[2]) p = k;
      if (long_pulse[2]) begin nlong++; lstep = k; end
    end
    for (int k = 1; k <= 15; k++) begin
      step('1, 1'b1);
      if (long_pulse[2]) nlong++;
      if (release_pulse[2] && r < 0) r = k;
    end
    check_eq("t4_long_once", 32'(nlong), 32'd1);
    check_eq("t4_long_offset", 32'(lstep - p), 32'(LONG - 1));
    check_eq("t4_release_lat", 32'(r), 32'd6);
    nlong = 0; p = -1;
    for (int k = 1; k <= 7; k++) begin
      step(3'b011, 1'b1);
      if (press_pulse[2]) p = k;
      if (long_pulse[2]) nlong++;
    end
    for (int k = 1; k <= 15; k++) begin step('1, 1'b1); if (long_pulse[2]) nlong++; end
    check_eq("t4_short_pressed", 32'(p), 32'd6);
    check_eq("t4_short_no_long", 32'(nlong), 32'd0);

    // 5: simultaneous presses and counter wrap
    base = m_count;
    triple_seen = 1'b0;
    for (int k = 0; k < 8; k++) begin
      step(3'b000, 1'b1);
      if (press_pulse == 3'b111) triple_seen = 1'b1;
    end
    check_eq("t5_triple_pulse", 32'(triple_seen), 32'd1);
    check_eq("t5_count_plus3", 32'(press_count), 32'(8'(base + 8'd3)));
    for (int k = 0; k < 8; k++) step('1, 1'b1);
    for (int n = 0; n < 260 && m_count != 8'd254; n++) begin
      if (8'(8'd254 - m_count) >= 8'd3) press_and_release(3'b000);
      else press_and_release(3'b110);
    end
    check_eq("t5_at_254", 32'(press_count), 32'd254);
    press_and_release(3'b000);
    check_eq("t5_wrap", 32'(press_count), 32'd1);

    // 6: reset while button 0 is held
    for (int k = 0; k < 8; k++) step(3'b110, 1'b1);
    for (int k = 0; k < 3; k++) begin
      step(3'b110, 1'b0);
      check_eq("t6_in_reset", {btn_state, press_pulse, release_pulse, long_pulse, press_count}, 32'd0);
    end
    p = -1;
    for (int k = 1; k <= 20; k++) begin
      step(3'b110, 1'b1);
      if (press_pulse[0] && p < 0) p = k;
    end
    check_eq("t6_press_after_reset", 32'(p), 32'd6);
    check_eq("t6_count", 32'(press_count), 32'd1);
    for (int k = 0; k < 10; k++) step('1, 1'b1);

    // Randomized pin activity with occasional resets
    lvl = '1;
    for (int i = 0; i < NB; i++) rem[i] = 0;
    for (int c = 0; c < 2000; c++) begin
      for (int i = 0; i < NB; i++) begin
        if (rem[i] == 0) begin
          lvl[i] = 1'($urandom_range(0, 1));
          rem[i] = int'($urandom_range(1, 16));
        end
        rem[i]--;
      end
      if ($urandom_range(0, 299) == 0) begin
        for (int k = 0; k < int'($urandom_range(1, 3)); k++) step(lvl, 1'b0);
      end else begin
        step(lvl, 1'b1);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
